exibe_sequencia: RTL and testbench
==================================

# exibe_sequencia

Sequence generator and presenter for the MindFocus memory game. Fills a 16-entry sequence memory from a free-running 8-bit LFSR, then plays the first `rodada+1` entries to the player on four one-hot LEDs with fixed on/off timing. It is the write/stimulus side of the game: the checker datapath reads the same sequence through a combinational read port and compares it against button presses.

## Interface

Parameters:

- `T_ON`, default 500: cycles each LED stays lit per step; must be ≥1.
- `T_OFF`, default 250: dark cycles after each step; must be ≥1.
- `SEMENTE`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:

- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low.
- `gerar`  in  1: request a new sequence; level sampled at the edge.
- `iniciar`  in  1: request playback; level sampled at the edge.
- `rodada`  in  4: index of the last step to show; registered on accepted `iniciar`.
- `ler_endereco`  in  4: read address for the checker.
- `ler_dado`  out  2: `mem[ler_endereco]`, combinational.
- `leds`  out  4: one-hot of the current step value (`4'b0001 << mem[passo]`) or 0.
- `ocupado`  out  1: high in GERA, ACENDE and APAGA.
- `valida`  out  1: high once a complete sequence has been generated.
- `pronto`  out  1: one-cycle pulse at end of playback.
- `db_estado`  out  4: state code.

## Operation

- LFSR:
  - 8-bit, advances every cycle from reset release.
  - Feedback `q[7]^q[5]^q[4]^q[3]` is shifted in at bit 0.
  - Shift direction is left.
- States and codes: INICIAL=0, GERA=1, ESPERA=2, ACENDE=3, APAGA=4, FIM=5.
- INICIAL:
  - `gerar` → GERA, with `addr`=0.
  - `iniciar` is ignored.
- GERA:
  - Each edge writes `mem[addr] <= lfsr[1:0]`, using the value before that edge's shift, then increments `addr`.
  - After the write at `addr`=15 → ESPERA and `valida` is set to 1.
  - `gerar` and `iniciar` are ignored.
- ESPERA:
  - `gerar` → GERA, and `valida` is cleared. If `gerar` and `iniciar` are both high, `gerar` wins.
  - `iniciar` → ACENDE, with `passo`=0, timer=0, and `rodada` latched.
- ACENDE:
  - `leds` = one-hot of `mem[passo]`.
  - After T_ON cycles → APAGA, with timer=0.
- APAGA:
  - `leds`=0.
  - After T_OFF cycles: if `passo`==latched `rodada` → FIM, else increment `passo` and → ACENDE.
- FIM:
  - `pronto`=1 for exactly this cycle, then → ESPERA.
- `gerar` and `iniciar` are ignored in GERA, ACENDE, APAGA and FIM.
- Widths:
  - Timer width is clog2(max(T_ON,T_OFF)+1).
  - `passo` and `addr` are 4 bits.
  - `rodada`=15 plays all 16 entries. No wrap occurs, because the comparison precedes the increment.

## Timing

- Reset (asynchronous assert, any state):
  - State → INICIAL.
  - `leds`=0, `ocupado`=0, `valida`=0, `pronto`=0, `db_estado`=0.
  - All `mem` entries = 0 and `lfsr`=SEMENTE.
  - Outputs change without waiting for a clock edge.
- Generation takes exactly 16 cycles from entering GERA to entering ESPERA.
- Playback, with `iniciar` accepted at edge k:
  - `leds` is nonzero from k+1 for exactly T_ON cycles, then 0 for T_OFF cycles, repeated per step.
  - `pronto` is high in cycle k+1+(rodada+1)·(T_ON+T_OFF).
- `ler_dado` has zero latency. During GERA it may return entries not yet overwritten.
- Changing `rodada` after acceptance has no effect on the current playback.

## Structure

- Shared include `mindfocus_defs.vh` holds:
  - the state codes,
  - the LFSR width and tap constants,
  - the sequence depth (16).
- Sub-module `lfsr8`:
  - Ports: `clock`, `reset`, parameter `SEMENTE`, output `q[7:0]`.
  - Free-running.
- Top FSM, timer, `passo`/`addr` counters and the 16×2 register-file memory live in `exibe_sequencia`.
- `db_estado` feeds the existing `hexa7seg` display instance at the top level.

## Test plan

The bench uses T_ON=4, T_OFF=2.

1. Reset sequence: hold `reset`=0 for 3 cycles → all outputs 0 and `db_estado`=0. Release, and pulse `iniciar` with no `gerar` → state stays 0 and `leds` stays 0.
2. Generation: `gerar`=1 at the first edge after reset release → `ocupado`=1 for 16 cycles, then `valida`=1 and `db_estado`=2. `ler_dado` at addresses 0,1,2 = 2,1,2 (LFSR A5→4A→95→2A).
3. Single-step playback: after test 2, `rodada`=0, `iniciar` pulse → `leds`=4'b0100 for 4 cycles, 0 for 2 cycles, `pronto` pulse at k+7, then `db_estado`=2.
4. Three-step playback: `rodada`=2 → `leds` shows 0100, 0010, 0100, each for 4 cycles separated by 2 dark cycles. `pronto` at k+19. Toggling `rodada` and `gerar` mid-playback changes nothing.
5. Priority: `gerar` and `iniciar` both high in ESPERA → GERA entered, `valida`=0, `leds` stays 0.
6. Reset mid-playback: assert `reset` during ACENDE between clock edges → `leds`=0 and `valida`=0 immediately, and `ler_dado`=0 at every address.

Source files
------------

// File: rtl/exibe_sequencia_pkg.sv
// Shared constants for the MindFocus sequence presenter: state codes,
// LFSR geometry and sequence depth, plus the LED one-hot helper.
package exibe_sequencia_pkg;

  // State codes (also driven out on db_estado for the 7-segment debug display)
  localparam logic [3:0] ST_INICIAL = 4'd0;
  localparam logic [3:0] ST_GERA    = 4'd1;
  localparam logic [3:0] ST_ESPERA  = 4'd2;
  localparam logic [3:0] ST_ACENDE  = 4'd3;
  localparam logic [3:0] ST_APAGA   = 4'd4;
  localparam logic [3:0] ST_FIM     = 4'd5;

  // LFSR: 8 bits, feedback q[7]^q[5]^q[4]^q[3] shifted in at bit 0
  localparam int                LFSR_W    = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // Sequence memory: 16 entries of 2 bits, addressed by 4-bit counters
  localparam int PROFUNDIDADE = 16;
  localparam int END_W        = 4;

  // One-hot LED pattern for a 2-bit sequence value
  function automatic logic [3:0] um_quente(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/exibe_sequencia_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, left shift, reloaded with SEMENTE on reset.
module lfsr8
  import exibe_sequencia_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEMENTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign q    = r_q;

  // Advance one step every cycle while out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= SEMENTE;
    end else begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence generator / presenter: fills a 16x2 memory from the LFSR, then
// plays the first rodada+1 entries on four one-hot LEDs with fixed timing.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int          T_ON    = 500,
  parameter int          T_OFF   = 250,
  parameter logic [7:0]  SEMENTE = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gerar,
  input  logic             iniciar,
  input  logic [END_W-1:0] rodada,
  input  logic [END_W-1:0] ler_endereco,
  output logic [1:0]       ler_dado,
  output logic [3:0]       leds,
  output logic             ocupado,
  output logic             valida,
  output logic             pronto,
  output logic [3:0]       db_estado
);

  localparam int MAX_T = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam logic [TW-1:0]    ON_ULT   = TW'(T_ON - 1);
  localparam logic [TW-1:0]    OFF_ULT  = TW'(T_OFF - 1);
  localparam logic [END_W-1:0] ADDR_ULT = END_W'(PROFUNDIDADE - 1);

  logic [3:0]       r_estado;
  logic [END_W-1:0] r_addr;
  logic [END_W-1:0] r_passo;
  logic [END_W-1:0] r_rodada;
  logic [TW-1:0]    r_timer;
  logic             r_valida;
  logic [1:0]       r_mem [PROFUNDIDADE];

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_grava;
  logic              w_unused_lfsr;

  lfsr8 #(
    .SEMENTE (SEMENTE)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Only the two low LFSR bits become sequence values
  assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:2];

  assign w_grava = (r_estado == ST_GERA);

  // Sequence memory: cleared on reset, written one entry per cycle in GERA
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        r_mem[i] <= 2'b00;
      end
    end else if (w_grava) begin
      r_mem[r_addr] <= w_lfsr[1:0];
    end
  end

  // Control FSM with step timer and address/step counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= ST_INICIAL;
      r_addr   <= '0;
      r_passo  <= '0;
      r_rodada <= '0;
      r_timer  <= '0;
      r_valida <= 1'b0;
    end else begin
      case (r_estado)
        ST_INICIAL: begin
          if (gerar) begin
            r_estado <= ST_GERA;
            r_addr   <= '0;
          end
        end
        ST_GERA: begin
          r_addr <= r_addr + END_W'(1);
          if (r_addr == ADDR_ULT) begin
            r_estado <= ST_ESPERA;
            r_valida <= 1'b1;
          end
        end
        ST_ESPERA: begin
          // gerar takes priority over iniciar
          if (gerar) begin
            r_estado <= ST_GERA;
            r_addr   <= '0;
            r_valida <= 1'b0;
          end else if (iniciar) begin
            r_estado <= ST_ACENDE;
            r_passo  <= '0;
            r_timer  <= '0;
            r_rodada <= rodada;
          end
        end
        ST_ACENDE: begin
          if (r_timer == ON_ULT) begin
            r_estado <= ST_APAGA;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_APAGA: begin
          if (r_timer == OFF_ULT) begin
            r_timer <= '0;
            // Compare before increment so rodada=15 never wraps passo
            if (r_passo == r_rodada) begin
              r_estado <= ST_FIM;
            end else begin
              r_passo  <= r_passo + END_W'(1);
              r_estado <= ST_ACENDE;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_FIM: begin
          r_estado <= ST_ESPERA;
        end
        default: begin
          r_estado <= ST_INICIAL;
        end
      endcase
    end
  end

  assign ler_dado  = r_mem[ler_endereco];
  assign leds      = (r_estado == ST_ACENDE) ? um_quente(r_mem[r_passo]) : 4'b0000;
  assign ocupado   = (r_estado == ST_GERA) || (r_estado == ST_ACENDE) || (r_estado == ST_APAGA);
  assign valida    = r_valida;
  assign pronto    = (r_estado == ST_FIM);
  assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Randomized self-checking bench for exibe_sequencia (T_ON=4, T_OFF=2).
`timescale 1ns/1ps
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;

  logic       clock;
  logic       reset;
  logic       gerar;
  logic       iniciar;
  logic [3:0] rodada;
  logic [3:0] ler_endereco;
  logic [1:0] ler_dado;
  logic [3:0] leds;
  logic       ocupado;
  logic       valida;
  logic       pronto;
  logic [3:0] db_estado;

  int n_vec;
  int n_err;

  // Reference state: LFSR value the DUT should hold, and expected memory
  logic [7:0] m_lfsr;
  logic [1:0] exp_mem [16];

  exibe_sequencia #(
    .T_ON    (T_ON),
    .T_OFF   (T_OFF),
    .SEMENTE (8'hA5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .gerar        (gerar),
    .iniciar      (iniciar),
    .rodada       (rodada),
    .ler_endereco (ler_endereco),
    .ler_dado     (ler_dado),
    .leds         (leds),
    .ocupado      (ocupado),
    .valida       (valida),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  // One clock; the reference LFSR advances whenever the DUT is out of reset
  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic read_check(input int a, input logic [1:0] exp, input string tag);
    ler_endereco = 4'(a);
    #1;
    check_val(tag, {30'd0, ler_dado}, {30'd0, exp});
  endtask

  // Generation: expected entries are the low bits of successive LFSR values
  task automatic gen_seq(input bit both);
    gerar   = 1'b1;
    iniciar = both;
    tick();
    gerar   = 1'b0;
    iniciar = 1'b0;
    check_val("gera_valida0", {31'd0, valida}, 32'd0);
    check_val("gera_leds0", {28'd0, leds}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = m_lfsr[1:0];
      check_val("gera_ocupado", {31'd0, ocupado}, 32'd1);
      check_val("gera_estado", {28'd0, db_estado}, 32'd1);
      tick();
    end
    check_val("gera_fim_ocupado", {31'd0, ocupado}, 32'd0);
    check_val("gera_fim_valida", {31'd0, valida}, 32'd1);
    check_val("gera_fim_estado", {28'd0, db_estado}, 32'd2);
    for (int a = 0; a < 16; a++) read_check(a, exp_mem[a], "mem_read");
    ler_endereco = 4'd0;
    $display("gen both=%0d mem0..3=%0d %0d %0d %0d", both, exp_mem[0], exp_mem[1], exp_mem[2], exp_mem[3]);
  endtask

  // Playback: expected LED trace built from steps, ON and OFF durations
  task automatic play(input logic [3:0] r);
    logic [3:0] q[$];
    logic [3:0] oh;
    q.delete();
    for (int s = 0; s <= int'(r); s++) begin
      oh = 4'b0001 << exp_mem[s];
      for (int t = 0; t < T_ON; t++) q.push_back(oh);
      for (int t = 0; t < T_OFF; t++) q.push_back(4'b0000);
    end
    rodada  = r;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int j = 0; j < q.size(); j++) begin
      check_val("play_leds", {28'd0, leds}, {28'd0, q[j]});
      check_val("play_pronto", {31'd0, pronto}, 32'd0);
      check_val("play_ocupado", {31'd0, ocupado}, 32'd1);
      // Inputs that must be ignored during playback
      rodada  = 4'($urandom_range(0, 15));
      gerar   = 1'($urandom_range(0, 1));
      iniciar = 1'($urandom_range(0, 1));
      tick();
    end
    gerar   = 1'b0;
    iniciar = 1'b0;
    check_val("fim_pronto", {31'd0, pronto}, 32'd1);
    check_val("fim_estado", {28'd0, db_estado}, 32'd5);
    check_val("fim_leds", {28'd0, leds}, 32'd0);
    tick();
    check_val("espera_estado", {28'd0, db_estado}, 32'd2);
    check_val("espera_pronto", {31'd0, pronto}, 32'd0);
    check_val("espera_valida", {31'd0, valida}, 32'd1);
    $display("play rodada=%0d cycles=%0d", r, q.size());
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b0;
    gerar        = 1'b0;
    iniciar      = 1'b0;
    rodada       = 4'd0;
    ler_endereco = 4'd0;
    m_lfsr       = 8'hA5;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) tick();
    check_val("rst_leds", {28'd0, leds}, 32'd0);
    check_val("rst_ocupado", {31'd0, ocupado}, 32'd0);
    check_val("rst_valida", {31'd0, valida}, 32'd0);
    check_val("rst_pronto", {31'd0, pronto}, 32'd0);
    check_val("rst_estado", {28'd0, db_estado}, 32'd0);
    $display("reset applied");

    reset  = 1'b1;
    m_lfsr = 8'hA5;

    // Generation at the first edge after release: LFSR A5->4A->95->2A
    gen_seq(1'b0);
    read_check(0, 2'd2, "seed_mem0");
    read_check(1, 2'd1, "seed_mem1");
    read_check(2, 2'd2, "seed_mem2");
    ler_endereco = 4'd0;

    // Single step, then three steps
    play(4'd0);
    play(4'd2);

    // Priority: gerar wins over iniciar
    gen_seq(1'b1);

    // Randomized mix of idle, generation and playback
    for (int it = 0; it < 12; it++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
          tick();
          check_val("idle_estado", {28'd0, db_estado}, 32'd2);
        end
      end else if (kind == 1) begin
        gen_seq(1'($urandom_range(0, 1)));
      end else begin
        play(4'($urandom_range(0, 15)));
      end
    end
    play(4'd15);

    // Reset mid-playback, asserted between clock edges
    rodada  = 4'd3;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check_val("abort_leds_on", {28'd0, leds}, {28'd0, 4'b0001 << exp_mem[0]});
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_val("abort_leds", {28'd0, leds}, 32'd0);
    check_val("abort_valida", {31'd0, valida}, 32'd0);
    check_val("abort_ocupado", {31'd0, ocupado}, 32'd0);
    check_val("abort_estado", {28'd0, db_estado}, 32'd0);
    for (int a = 0; a < 16; a++) read_check(a, 2'd0, "abort_mem");
    ler_endereco = 4'd0;
    $display("reset mid-playback");
    tick();
    reset  = 1'b1;
    m_lfsr = 8'hA5;

    // iniciar without a sequence is ignored
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check_val("ign_estado", {28'd0, db_estado}, 32'd0);
    check_val("ign_leds", {28'd0, leds}, 32'd0);
    check_val("ign_ocupado", {31'd0, ocupado}, 32'd0);
    $display("iniciar ignored in INICIAL");

    gen_seq(1'b0);
    play(4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
